// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer between the MEM stage and data memory.
// Define STB_MERGE_EN to let a store to the tail word merge into the tail entry.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   st_valid,
    input  logic [31:0]            st_addr,
    input  logic [3:0]             st_be,
    input  logic [31:0]            st_data,
    output logic                   st_ready,
    input  logic                   ld_valid,
    input  logic [31:0]            ld_addr,
    output logic                   ld_hazard,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    output logic [3:0]             mem_be,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_ack,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [29:0]   word_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;
    logic          merge_hit;
    logic          accept;
    logic          push;
    logic          pop;
    logic          unused_bits;

    // Merging never targets the head: the head may be on the bus right now.
`ifdef STB_MERGE_EN
    logic [AW-1:0] tail_ptr;
    assign tail_ptr  = wr_ptr - AW'(1);
    assign merge_hit = (cnt >= (AW+1)'(2)) && (word_q[tail_ptr] == st_addr[31:2]);
`else
    assign merge_hit = 1'b0;
`endif

    assign st_ready    = (cnt < FULL_CNT) || merge_hit;
    assign accept      = st_valid && st_ready && (st_be != 4'b0000);
    assign push        = accept && !merge_hit;
    assign empty       = (cnt == '0);
    assign mem_req     = !empty;
    assign pop         = mem_req && mem_ack;
    assign count       = cnt;
    assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

    // Head outputs are forced to zero when nothing is pending, which also covers reset.
    assign mem_addr  = mem_req ? {word_q[rd_ptr], 2'b00} : 32'h0;
    assign mem_be    = mem_req ? be_q[rd_ptr] : 4'h0;
    assign mem_wdata = mem_req ? data_q[rd_ptr] : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr] <= st_addr[31:2];
            be_q[wr_ptr]   <= st_be;
            data_q[wr_ptr] <= st_data;
        end
`ifdef STB_MERGE_EN
        else if (accept && merge_hit) begin
            be_q[tail_ptr] <= be_q[tail_ptr] | st_be;
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) data_q[tail_ptr][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
`endif
    end

    // An entry is occupied when its distance from the head is below the count.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, AW'(i) - rd_ptr} < cnt) && (word_q[i] == ld_addr[31:2]))
                ld_hazard = ld_valid;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized and directed bench for store_buffer with a queue-based model.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef STB_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          st_valid;
    logic [31:0]   st_addr;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic          ld_hazard;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic          empty;
    logic [CW-1:0] count;

    typedef struct packed {
        logic [29:0] w;
        logic [3:0]  be;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int n_checks = 0;
    int n_fail = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_be(st_be), .st_data(st_data),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic bit m_merge(logic [31:0] a);
        if (q.size() < 2) return 1'b0;
        return MERGE && (q[q.size()-1].w == a[31:2]);
    endfunction

    function automatic bit m_ready(logic [31:0] a);
        return (q.size() < DEPTH) || m_merge(a);
    endfunction

    function automatic bit m_hazard();
        bit h = 1'b0;
        foreach (q[i]) if (q[i].w == ld_addr[31:2]) h = 1'b1;
        return ld_valid && h;
    endfunction

    // One clock edge: the model applies the rules to the inputs held across the edge.
    task automatic tick();
        bit mrg, acc, pp;
        ent_t e, t;
        mrg = m_merge(st_addr);
        acc = st_valid && m_ready(st_addr) && (st_be != 4'b0000);
        pp  = (q.size() != 0) && mem_ack;
        e   = {st_addr[31:2], st_be, st_data};
        @(posedge clk);
        if (acc && mrg) begin
            t = q[q.size()-1];
            for (int b = 0; b < 4; b++) if (e.be[b]) t.d[8*b +: 8] = e.d[8*b +: 8];
            t.be = t.be | e.be;
            q[q.size()-1] = t;
        end
        if (pp) void'(q.pop_front());
        if (acc && !mrg) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_idle();
        st_valid = 1'b0; st_addr = '0; st_be = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        st_valid = 1'b1; st_addr = a; st_be = be; st_data = d;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic drain();
        st_valid = 1'b0; mem_ack = 1'b1;
        repeat (DEPTH + 1) tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset_n = 1'b0;
        q.delete();
        ld_valid = 1'b1;
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL rst_st_ready: got %b want 1", st_ready); end
        n_checks++; if (ld_hazard !== 1'b0) begin n_fail++; $display("FAIL rst_ld_hazard: got %b want 0", ld_hazard); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        n_checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_mem_bus: got %h/%b/%h want 0/0/0", mem_addr, mem_be, mem_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ld_valid = 1'b0;
    endtask

    task automatic test_basic();
        set_idle();
        st_valid = 1'b1; st_addr = 32'h0000_1006; st_be = 4'b1100; st_data = 32'hBEEF_BEEF;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass: got %b want 0", mem_req); end
        n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", st_ready); end
        tick();
        st_valid = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %b want 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h0000_1004) begin n_fail++; $display("FAIL basic_addr: got %h want 00001004", mem_addr); end
        n_checks++; if (mem_be !== 4'b1100) begin n_fail++; $display("FAIL basic_be: got %b want 1100", mem_be); end
        n_checks++; if (mem_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL basic_data: got %h want beefbeef", mem_wdata); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", count); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %b want 1", empty); end
        st_valid = 1'b1; st_addr = 32'h0000_3000; st_be = 4'b0000; st_data = 32'h1234_5678;
        #1;
        n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL be0_ready: got %b want 1", st_ready); end
        tick();
        st_valid = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL be0_discard: got empty=%b want 1", empty); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL idle_ack: got %0d want 0", count); end
    endtask

    task automatic test_full();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'h100 + 32'(16 * i); st_be = 4'hF; st_data = 32'hA000_0000 + 32'(i);
            #1;
            n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d: got %b want 1", i, st_ready); end
            tick();
        end
        st_addr = 32'h140; st_data = 32'hA000_0004;
        #1;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
        n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", st_ready); end
        tick();
        #1;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_hold: got %0d want 4", count); end
        mem_ack = 1'b1;
        #1;
        n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready: got %b want 0", st_ready); end
        tick();
        #1;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_after_pop: got %0d want 3", count); end
        n_checks++; if (mem_addr !== 32'h110) begin n_fail++; $display("FAIL full_head1: got %h want 00000110", mem_addr); end
        n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL full_space: got %b want 1", st_ready); end
        tick();
        st_valid = 1'b0;
        #1;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pushpop: got %0d want 3", count); end
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (mem_addr !== 32'h120 + 32'(16 * k) || mem_wdata !== 32'hA000_0002 + 32'(k)) begin
                n_fail++; $display("FAIL drain_order%0d: got %h/%h want %h/%h", k, mem_addr, mem_wdata, 32'h120 + 32'(16 * k), 32'hA000_0002 + 32'(k));
            end
            tick();
        end
        mem_ack = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drained: got %b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        set_idle();
        store(32'h200, 4'hF, 32'h1111_0000);
        store(32'h204, 4'hF, 32'h2222_0000);
        st_valid = 1'b1; st_addr = 32'h208; st_be = 4'hF; st_data = 32'h3333_0000;
        mem_ack = 1'b1;
        tick();
        st_valid = 1'b0; mem_ack = 1'b0;
        #1;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", count); end
        n_checks++; if (mem_addr !== 32'h204 || mem_wdata !== 32'h2222_0000) begin
            n_fail++; $display("FAIL b2b_head: got %h/%h want 00000204/22220000", mem_addr, mem_wdata);
        end
        drain();
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b want 1", empty); end
    endtask

    task automatic test_hazard();
        set_idle();
        store(32'h2000, 4'hF, 32'hCAFE_F00D);
        ld_valid = 1'b1; ld_addr = 32'h2003;
        #1;
        n_checks++; if (ld_hazard !== 1'b1) begin n_fail++; $display("FAIL haz_match: got %b want 1", ld_hazard); end
        ld_addr = 32'h2004;
        #1;
        n_checks++; if (ld_hazard !== 1'b0) begin n_fail++; $display("FAIL haz_other: got %b want 0", ld_hazard); end
        ld_valid = 1'b0; ld_addr = 32'h2003;
        #1;
        n_checks++; if (ld_hazard !== 1'b0) begin n_fail++; $display("FAIL haz_noload: got %b want 0", ld_hazard); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; ld_valid = 1'b1;
        #1;
        n_checks++; if (ld_hazard !== 1'b0) begin n_fail++; $display("FAIL haz_drained: got %b want 0", ld_hazard); end
        ld_valid = 1'b0;
    endtask

    task automatic test_merge();
        set_idle();
        store(32'h10, 4'hF, 32'h1111_1111);
        store(32'h20, 4'b0001, 32'h0000_0022);
        store(32'h21, 4'b0010, 32'hABAB_ABAB);
        #1;
        n_checks++; if (count !== (MERGE ? 3'd2 : 3'd3)) begin n_fail++; $display("FAIL merge_count: got %0d want %0d", count, MERGE ? 2 : 3); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        n_checks++; if (mem_addr !== 32'h20 || mem_be !== (MERGE ? 4'b0011 : 4'b0001) || mem_wdata !== (MERGE ? 32'h0000_AB22 : 32'h0000_0022)) begin
            n_fail++; $display("FAIL merge_tail: got %h/%b/%h want 00000020/%b/%h", mem_addr, mem_be, mem_wdata,
                               MERGE ? 4'b0011 : 4'b0001, MERGE ? 32'h0000_AB22 : 32'h0000_0022);
        end
        drain();
        store(32'h30, 4'hF, 32'h3030_3030);
        store(32'h31, 4'b0010, 32'h5555_5555);
        #1;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL merge_head: got %0d want 2", count); end
        store(32'h40, 4'hF, 32'h4040_4040);
        store(32'h50, 4'hF, 32'h5050_5050);
        st_valid = 1'b1; st_addr = 32'h53; st_be = 4'b1000; st_data = 32'h7777_7777;
        #1;
        n_checks++; if (st_ready !== MERGE) begin n_fail++; $display("FAIL merge_full_ready: got %b want %b", st_ready, MERGE); end
        tick();
        st_valid = 1'b0;
        #1;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL merge_full_count: got %0d want 4", count); end
        drain();
    endtask

    task automatic test_reset_mid();
        set_idle();
        store(32'h600, 4'hF, 32'h6);
        store(32'h604, 4'hF, 32'h7);
        store(32'h608, 4'hF, 32'h8);
        ld_valid = 1'b1; ld_addr = 32'h600;
        #2;
        reset_n = 1'b0;
        q.delete();
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req: got %b want 0", mem_req); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", count); end
        n_checks++; if (ld_hazard !== 1'b0) begin n_fail++; $display("FAIL rmid_hazard: got %b want 0", ld_hazard); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_addr: got %h want 0", mem_addr); end
        @(negedge clk);
        reset_n = 1'b1;
        ld_valid = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL rmid_ack: got count=%0d empty=%b want 0/1", count, empty); end
    endtask

    task automatic test_random();
        logic [CW-1:0] exp_cnt;
        set_idle();
        for (int n = 0; n < 400; n++) begin
            st_valid = ($urandom_range(0, 9) < 6);
            st_addr  = 32'h40 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            st_be    = 4'($urandom_range(0, 15));
            st_data  = $urandom;
            mem_ack  = $urandom_range(0, 1) == 1;
            ld_valid = $urandom_range(0, 1) == 1;
            ld_addr  = 32'h40 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
            #1;
            exp_cnt = CW'(q.size());
            n_checks++; if (count !== exp_cnt) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, count, exp_cnt); end
            n_checks++; if (mem_req !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_req@%0d: got %b want %b", n, mem_req, q.size() != 0); end
            n_checks++; if (empty !== (q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty@%0d: got %b want %b", n, empty, q.size() == 0); end
            n_checks++; if (st_ready !== m_ready(st_addr)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", n, st_ready, m_ready(st_addr)); end
            n_checks++; if (ld_hazard !== m_hazard()) begin n_fail++; $display("FAIL rnd_hazard@%0d: got %b want %b", n, ld_hazard, m_hazard()); end
            if (q.size() != 0) begin
                n_checks++; if (mem_addr !== {q[0].w, 2'b00} || mem_be !== q[0].be || mem_wdata !== q[0].d) begin
                    n_fail++; $display("FAIL rnd_head@%0d: got %h/%b/%h want %h/%b/%h", n, mem_addr, mem_be, mem_wdata, {q[0].w, 2'b00}, q[0].be, q[0].d);
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_hazard();
        test_merge();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of entries; a power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port st_valid, input, 1 bit: store request from the MEM stage.
REQ-005 SHALL have port st_addr, input, 32 bits: store byte address; bits [31:2] give the word address.
REQ-006 SHALL have port st_be, input, 4 bits: byte enables from the store decoder.
REQ-007 SHALL have port st_data, input, 32 bits: store data, already lane-replicated by the decoder.
REQ-008 SHALL have port st_ready, output, 1 bit: the store is accepted this cycle.
REQ-009 SHALL have port ld_valid, input, 1 bit: a load is in the MEM stage.
REQ-010 SHALL have port ld_addr, input, 32 bits: the load byte address.
REQ-011 SHALL have port ld_hazard, output, 1 bit: the load word matches a pending entry, so the pipeline stalls.
REQ-012 SHALL have port mem_req, output, 1 bit: a write request to data memory or the bridge.
REQ-013 SHALL have port mem_addr, output, 32 bits: the head word address, with bits [1:0] always 2'b00.
REQ-014 SHALL have port mem_be, output, 4 bits, and port mem_wdata, output, 32 bits: the head byte enables and data.
REQ-015 SHALL have port mem_ack, input, 1 bit: memory accepted the write this cycle.
REQ-016 SHALL have port empty, output, 1 bit, and port count, output, clog2(DEPTH)+1 bits: the occupancy.

Function
REQ-017 SHALL operate as an in-order FIFO of {word address, be, data} entries; pointers wrap modulo DEPTH.
REQ-018 SHALL push when st_valid && st_ready && st_be!=0; st_valid with st_be==0 is accepted and discarded, with no entry.
REQ-019 SHALL drive st_ready = (count < DEPTH) from registered state only; a pop in the same cycle does not free space for a push while full.
REQ-020 SHALL drive mem_req = !empty; mem_addr, mem_be and mem_wdata SHALL show the head entry and stay stable until mem_ack.
REQ-021 SHALL pop the head on mem_req && mem_ack; mem_ack while mem_req=0 is ignored.
REQ-022 SHALL make a pushed entry visible on mem_req no earlier than the cycle after the push (1-cycle latency); no bypass.
REQ-023 SHALL handle a simultaneous push and pop with count unchanged, both pointers advancing.
REQ-024 SHALL make ld_hazard combinational: ld_valid && (some occupied entry word address == ld_addr[31:2]); it is 0 when empty.
REQ-025 SHALL never drop, reorder or duplicate entries; at most one pop per cycle.

Reset
REQ-026 SHALL, while reset_n=0 (taking effect immediately), clear pointers and count, and drive empty=1, mem_req=0, st_ready=1, ld_hazard=0.
REQ-027 SHALL reset mem_addr, mem_be and mem_wdata to 0.
REQ-028 SHALL discard pending entries on a reset mid-operation, including the head awaiting mem_ack; mem_ack after reset is ignored.

Configuration
REQ-029 SHALL define macro STB_MERGE_EN to enable write merging into the tail entry.
REQ-030 SHALL, with STB_MERGE_EN defined, merge an accepted store into the tail entry when count>=2 and its word address equals the tail's word address: st_be lanes overwrite data, be |= st_be, count is unchanged, and st_ready=1 even when full.
REQ-031 SHALL NOT merge into the head, including when count==1.
REQ-032 SHALL, without STB_MERGE_EN, allocate a new entry on every store.

Verification
REQ-033 SHALL cover: reset, then a store to 0x0000_1006 with be=1100 and data 0xBEEF_BEEF -> next cycle mem_req=1, mem_addr=0x0000_1004, mem_be=1100; mem_ack -> empty=1.
REQ-034 SHALL cover: mem_ack held 0 with 5 stores (DEPTH=4) -> st_ready=0 at count=4; the fifth store waits; releasing acks drains entries in order.
REQ-035 SHALL cover: count=2 with a simultaneous push and ack -> count stays 2 and the head advances to the next entry.
REQ-036 SHALL cover: pending store to 0x2000 and a load of 0x2003 -> ld_hazard=1; a load of 0x2004 -> ld_hazard=0; after drain, a load of 0x2003 -> ld_hazard=0.
REQ-037 SHALL cover: with STB_MERGE_EN, entries at 0x10 and 0x20, then an sb to 0x21 with be=0010 -> count=2 and the tail has be=OR and merged data; without the macro -> count=3.
REQ-038 SHALL cover: reset_n pulsed low with 3 entries and mem_req=1 -> mem_req=0 and count=0 immediately; an ack in the next cycle has no effect.
